alarm_controller: RTL and testbench

User-interface and alarm sequencer for the 24-hour BCD alarm clock. It decodes the debounced mode, increment and snooze buttons into a time-set and alarm-set state machine. It drives a one-cycle load strobe into the time-keeping digit counters and holds the alarm time. It also compares live time against the alarm and runs the ring, snooze and dismiss sequence, and selects and blinks what the 4-digit `segment7` multiplexer shows.

---
 rtl/alarm_controller.sv | 216 +++++++++++++++++++++
 tb/tb_alarm_controller.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// Button-driven time/alarm set sequencer with alarm compare, ring, snooze and display select.
// Button and tick effects appear one cycle after the pulse; no backpressure (inputs are single-cycle pulses).
module alarm_controller #(
  parameter int TIMEOUT_S      = 30,
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_S         = 60,
  parameter int ALARM_RESET_HL = 7
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        tick_1hz,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_snooze,
  input  logic        alarm_arm,
  input  logic [1:0]  cur_hh,
  input  logic [3:0]  cur_hl,
  input  logic [3:0]  cur_mh,
  input  logic [3:0]  cur_ml,
  input  logic [3:0]  cur_sh,
  input  logic [3:0]  cur_sl,
  output logic        set_load,
  output logic [1:0]  set_hh,
  output logic [3:0]  set_hl,
  output logic [3:0]  set_mh,
  output logic [3:0]  set_ml,
  output logic [15:0] disp_digit,
  output logic [3:0]  disp_en,
  output logic        alarm_ringing,
  output logic        buzzer,
  output logic        snoozing
);

  localparam int SNZ_LOAD = SNOOZE_MIN * 60;
  localparam int IDLE_W   = $clog2(TIMEOUT_S + 1);
  localparam int SNZ_W    = $clog2(SNZ_LOAD + 1);
  localparam int RING_W   = $clog2(RING_S + 1);

  typedef enum logic [2:0] {S_RUN, S_SET_TH, S_SET_TM, S_SET_AH, S_SET_AM, S_RING} state_t;

  state_t              r_state, w_state_nxt;
  logic [1:0]          r_ed_hh, r_al_hh, w_hinc_hh;
  logic [3:0]          r_ed_hl, r_ed_mh, r_ed_ml, r_al_hl, r_al_mh, r_al_ml;
  logic [3:0]          w_hinc_hl, w_minc_mh, w_minc_ml;
  logic [13:0]         r_cmt, w_set_vec;
  logic                r_blink, w_blink_nxt, r_match, r_match_d;
  logic                r_set_load, r_ringing, r_buzzer, r_snoozing, w_snoozing_nxt;
  logic [IDLE_W-1:0]   r_idle;
  logic [SNZ_W-1:0]    r_snz_cnt;
  logic [RING_W-1:0]   r_ring_cnt;
  logic                w_ld_cur, w_ld_alarm, w_wr_alarm, w_inc_h, w_inc_m, w_set_load_nxt, w_snz_start;
  logic                w_match_now, w_match_rise, w_snz_exp, w_any_btn, w_timeout, w_ring_done, w_enter_set;

  assign w_match_now  = alarm_arm && (cur_hh == r_al_hh) && (cur_hl == r_al_hl) && (cur_mh == r_al_mh)
                        && (cur_ml == r_al_ml) && (cur_sh == 4'd0) && (cur_sl == 4'd0);
  assign w_match_rise = r_match && !r_match_d;
  assign w_snz_exp    = r_snoozing && (r_snz_cnt == '0);
  assign w_any_btn    = btn_mode || btn_inc || btn_snooze;
  assign w_timeout    = !w_any_btn && (r_idle == IDLE_W'(TIMEOUT_S));
  assign w_ring_done  = r_ring_cnt == RING_W'(RING_S);

  // BCD increments of the edit buffer: hours wrap 23->00, minutes 59->00.
  always_comb begin
    w_hinc_hh = r_ed_hh;
    w_hinc_hl = r_ed_hl + 4'd1;
    if (r_ed_hh == 2'd2 && r_ed_hl == 4'd3) begin
      w_hinc_hh = 2'd0;
      w_hinc_hl = 4'd0;
    end else if (r_ed_hl == 4'd9) begin
      w_hinc_hh = r_ed_hh + 2'd1;
      w_hinc_hl = 4'd0;
    end
    w_minc_mh = r_ed_mh;
    w_minc_ml = r_ed_ml + 4'd1;
    if (r_ed_ml == 4'd9) begin
      w_minc_ml = 4'd0;
      w_minc_mh = (r_ed_mh == 4'd5) ? 4'd0 : r_ed_mh + 4'd1;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_cur       = 1'b0;
    w_ld_alarm     = 1'b0;
    w_wr_alarm     = 1'b0;
    w_inc_h        = 1'b0;
    w_inc_m        = 1'b0;
    w_set_load_nxt = 1'b0;
    w_snz_start    = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_match_rise || w_snz_exp) begin
          w_state_nxt = S_RING;
        end else if (btn_mode) begin
          w_state_nxt = S_SET_TH;
          w_ld_cur    = 1'b1;
        end
      end
      S_SET_TH, S_SET_AH: begin
        if (btn_mode)       w_state_nxt = (r_state == S_SET_TH) ? S_SET_TM : S_SET_AM;
        else if (btn_inc)   w_inc_h = 1'b1;
        else if (w_timeout) w_state_nxt = S_RUN;
      end
      S_SET_TM: begin
        if (btn_mode) begin
          w_state_nxt    = S_SET_AH;
          w_set_load_nxt = 1'b1;
          w_ld_alarm     = 1'b1;
        end else if (btn_inc) begin
          w_inc_m = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = S_RUN;
        end
      end
      S_SET_AM: begin
        if (btn_mode) begin
          w_state_nxt = S_RUN;
          w_wr_alarm  = 1'b1;
        end else if (btn_inc) begin
          w_inc_m = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RING: begin
        if (!alarm_arm || btn_mode) begin
          w_state_nxt = S_RUN;
        end else if (btn_snooze) begin
          w_state_nxt = S_RUN;
          w_snz_start = 1'b1;
        end else if (w_ring_done) begin
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // An expiry outside RUN simply drops the pending ring.
  always_comb begin
    w_snoozing_nxt = r_snoozing;
    if (w_snz_start) w_snoozing_nxt = 1'b1;
    if (w_snz_exp || w_state_nxt == S_RING || !alarm_arm) w_snoozing_nxt = 1'b0;
    w_enter_set = (w_state_nxt != r_state) && (w_state_nxt != S_RUN) && (w_state_nxt != S_RING);
    w_blink_nxt = tick_1hz ? !r_blink : r_blink;
    if (btn_inc || w_enter_set) w_blink_nxt = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state    <= S_RUN;
      {r_ed_hh, r_ed_hl, r_ed_mh, r_ed_ml} <= '0;
      r_al_hh    <= 2'd0;
      r_al_hl    <= 4'(ALARM_RESET_HL);
      r_al_mh    <= 4'd0;
      r_al_ml    <= 4'd0;
      r_cmt      <= '0;
      r_blink    <= 1'b1;
      r_match    <= 1'b0;
      r_match_d  <= 1'b0;
      r_set_load <= 1'b0;
      r_ringing  <= 1'b0;
      r_buzzer   <= 1'b0;
      r_snoozing <= 1'b0;
      r_idle     <= '0;
      r_snz_cnt  <= '0;
      r_ring_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_blink    <= w_blink_nxt;
      r_match    <= w_match_now;
      r_match_d  <= r_match;
      r_set_load <= w_set_load_nxt;
      r_ringing  <= (w_state_nxt == S_RING);
      r_buzzer   <= (w_state_nxt == S_RING) && w_blink_nxt;
      r_snoozing <= w_snoozing_nxt;
      if (w_any_btn)                                  r_idle <= '0;
      else if (tick_1hz && r_idle != IDLE_W'(TIMEOUT_S)) r_idle <= r_idle + IDLE_W'(1);
      if (w_snz_start)                          r_snz_cnt <= SNZ_W'(SNZ_LOAD);
      else if (tick_1hz && r_snz_cnt != '0)     r_snz_cnt <= r_snz_cnt - SNZ_W'(1);
      if (r_state != S_RING)                    r_ring_cnt <= '0;
      else if (tick_1hz && !w_ring_done)        r_ring_cnt <= r_ring_cnt + RING_W'(1);
      if (w_ld_cur)   {r_ed_hh, r_ed_hl, r_ed_mh, r_ed_ml} <= {cur_hh, cur_hl, cur_mh, cur_ml};
      if (w_ld_alarm) {r_ed_hh, r_ed_hl, r_ed_mh, r_ed_ml} <= {r_al_hh, r_al_hl, r_al_mh, r_al_ml};
      if (w_inc_h)    {r_ed_hh, r_ed_hl} <= {w_hinc_hh, w_hinc_hl};
      if (w_inc_m)    {r_ed_mh, r_ed_ml} <= {w_minc_mh, w_minc_ml};
      if (w_set_load_nxt) r_cmt <= {r_ed_hh, r_ed_hl, r_ed_mh, r_ed_ml};
      if (w_wr_alarm) {r_al_hh, r_al_hl, r_al_mh, r_al_ml} <= {r_ed_hh, r_ed_hl, r_ed_mh, r_ed_ml};
    end
  end

  // The edit buffer already holds the alarm during the load cycle, so present the committed copy then.
  assign w_set_vec = r_set_load ? r_cmt : {r_ed_hh, r_ed_hl, r_ed_mh, r_ed_ml};
  assign {set_hh, set_hl, set_mh, set_ml} = w_set_vec;
  assign set_load      = r_set_load;
  assign alarm_ringing = r_ringing;
  assign buzzer        = r_buzzer;
  assign snoozing      = r_snoozing;

  always_comb begin
    disp_digit = {2'b00, cur_hh, cur_hl, cur_mh, cur_ml};
    disp_en    = 4'b1111;
    case (r_state)
      S_SET_TH, S_SET_AH: begin
        disp_digit = {2'b00, r_ed_hh, r_ed_hl, r_ed_mh, r_ed_ml};
        disp_en    = {r_blink, r_blink, 2'b11};
      end
      S_SET_TM, S_SET_AM: begin
        disp_digit = {2'b00, r_ed_hh, r_ed_hl, r_ed_mh, r_ed_ml};
        disp_en    = {2'b11, r_blink, r_blink};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: set sequence, timeout, ring/snooze/dismiss, priorities and reset.
module tb_alarm_controller;
  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic reset, tick_1hz, btn_mode, btn_inc, btn_snooze, alarm_arm;
  logic [1:0] cur_hh;
  logic [3:0] cur_hl, cur_mh, cur_ml, cur_sh, cur_sl;
  logic set_load, alarm_ringing, buzzer, snoozing;
  logic [1:0] set_hh;
  logic [3:0] set_hl, set_mh, set_ml, disp_en;
  logic [15:0] disp_digit;

  alarm_controller dut (
    .clk_in(clk_in), .reset(reset), .tick_1hz(tick_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .btn_snooze(btn_snooze), .alarm_arm(alarm_arm), .cur_hh(cur_hh), .cur_hl(cur_hl), .cur_mh(cur_mh),
    .cur_ml(cur_ml), .cur_sh(cur_sh), .cur_sl(cur_sl), .set_load(set_load), .set_hh(set_hh),
    .set_hl(set_hl), .set_mh(set_mh), .set_ml(set_ml), .disp_digit(disp_digit), .disp_en(disp_en),
    .alarm_ringing(alarm_ringing), .buzzer(buzzer), .snoozing(snoozing)
  );

  localparam logic [2:0] K_LOAD = 3'd1, K_RON = 3'd2, K_ROFF = 3'd3, K_SON = 3'd4, K_SOFF = 3'd5;
  typedef struct packed {logic [2:0] kind; logic [13:0] dat;} ev_t;
  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  bit  mon_en = 1'b0;
  logic p_ring = 1'b0, p_snz = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  task automatic expect_ev(input logic [2:0] k, input logic [13:0] d);
    ev_t e;
    e.kind = k;
    e.dat  = d;
    exp_q.push_back(e);
  endtask

  task automatic mon_check(input logic [2:0] k, input logic [13:0] d);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d dat=%h want none", k, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== k || e.dat !== d) begin
        bad++;
        $display("FAIL event: got kind=%0d dat=%h want kind=%0d dat=%h", k, d, e.kind, e.dat);
      end
    end
  endtask

  // Monitor: turns output activity into events and matches them against the expected queue.
  always @(negedge clk_in) begin
    if (mon_en) begin
      if (set_load === 1'b1) mon_check(K_LOAD, {set_hh, set_hl, set_mh, set_ml});
      if (alarm_ringing !== p_ring) mon_check(alarm_ringing ? K_RON : K_ROFF, 14'd0);
      if (snoozing !== p_snz) mon_check(snoozing ? K_SON : K_SOFF, 14'd0);
      p_ring = alarm_ringing;
      p_snz  = snoozing;
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic tick(input int n);
    tick_1hz = 1'b1;
    repeat (n) step();
    tick_1hz = 1'b0;
  endtask

  task automatic press(input logic m, input logic i, input logic s);
    btn_mode = m; btn_inc = i; btn_snooze = s;
    step();
    btn_mode = 1'b0; btn_inc = 1'b0; btn_snooze = 1'b0;
  endtask

  task automatic set_cur(input logic [1:0] hh, input logic [3:0] hl, input logic [3:0] mh,
                         input logic [3:0] ml, input logic [3:0] sh, input logic [3:0] sl);
    cur_hh = hh; cur_hl = hl; cur_mh = mh; cur_ml = ml; cur_sh = sh; cur_sl = sl;
  endtask

  // Alarm is 07:00; the registered match edge rings two edges after cur reaches 07:00:00.
  task automatic ring_up(input string name);
    set_cur(2'd0, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0);
    expect_ev(K_RON, 14'd0);
    step();
    chk({name, "_lat0"}, 16'(alarm_ringing), 16'd0);
    step();
    chk({name, "_lat1"}, 16'(alarm_ringing), 16'd1);
    set_cur(2'd0, 4'd7, 4'd0, 4'd0, 4'd0, 4'd1);
  endtask

  initial begin
    reset = 1'b1; tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; btn_snooze = 1'b0;
    alarm_arm = 1'b1;
    set_cur(2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    step(); step();
    reset = 1'b0;
    chk("rst_ring", 16'(alarm_ringing), 16'd0);
    chk("rst_buzz", 16'(buzzer), 16'd0);
    chk("rst_snz", 16'(snoozing), 16'd0);
    chk("rst_load", 16'(set_load), 16'd0);
    chk("rst_en", 16'(disp_en), 16'hF);
    chk("rst_set", 16'({set_hh, set_hl, set_mh, set_ml}), 16'h0000);
    mon_en = 1'b1;
    tick(5);
    chk("run_disp0", disp_digit, 16'h1234);
    set_cur(2'd1, 4'd3, 4'd4, 4'd5, 4'd0, 4'd9);
    #1 chk("run_disp1", disp_digit, 16'h1345);

    // Time set: 22:58 -> hours 22->23->00, minutes 58->59->00->01.
    set_cur(2'd2, 4'd2, 4'd5, 4'd8, 4'd1, 4'd0);
    press(1, 0, 0);
    chk("th_disp", disp_digit, 16'h2258);
    chk("th_en_entry", 16'(disp_en), 16'hF);
    tick(1);
    chk("th_en_blink", 16'(disp_en), 16'h3);
    press(0, 1, 0);
    chk("th_inc1", disp_digit, 16'h2358);
    chk("th_en_inc", 16'(disp_en), 16'hF);
    press(0, 1, 0);
    chk("th_wrap", disp_digit, 16'h0058);
    press(1, 0, 0);
    tick(1);
    chk("tm_en_blink", 16'(disp_en), 16'hC);
    repeat (3) press(0, 1, 0);
    chk("tm_disp", disp_digit, 16'h0001);
    expect_ev(K_LOAD, 14'h0001);
    press(1, 0, 0);
    chk("load_hi", 16'(set_load), 16'd1);
    chk("load_set", 16'({set_hh, set_hl, set_mh, set_ml}), 16'h0001);
    chk("ah_disp_alarm", disp_digit, 16'h0700);
    step();
    chk("load_lo", 16'(set_load), 16'd0);

    // SET_AM timeout: 30 idle ticks then back to RUN without committing.
    press(1, 0, 0);
    chk("am_disp", disp_digit, 16'h0700);
    tick(29);
    chk("am_to29", disp_digit, 16'h0700);
    tick(1);
    chk("am_to30", disp_digit, 16'h0700);
    step();
    chk("am_to_run", disp_digit, 16'h2258);
    chk("am_to_en", 16'(disp_en), 16'hF);

    // Ring, buzzer follows blink, snooze for 300 ticks, then dismiss with mode.
    set_cur(2'd0, 4'd6, 4'd5, 4'd9, 4'd5, 4'd9);
    step();
    ring_up("ring_a");
    chk("buzz0", 16'(buzzer), 16'd1);
    tick(1);
    chk("buzz1", 16'(buzzer), 16'd0);
    tick(1);
    chk("buzz2", 16'(buzzer), 16'd1);
    expect_ev(K_ROFF, 14'd0);
    expect_ev(K_SON, 14'd0);
    press(0, 0, 1);
    chk("snz_on", 16'(snoozing), 16'd1);
    tick(299);
    tick(1);
    chk("snz_300", 16'(alarm_ringing), 16'd0);
    expect_ev(K_RON, 14'd0);
    expect_ev(K_SOFF, 14'd0);
    step();
    chk("snz_ring", 16'(alarm_ringing), 16'd1);
    expect_ev(K_ROFF, 14'd0);
    press(1, 0, 0);
    chk("dismiss_ring", 16'(alarm_ringing), 16'd0);
    chk("dismiss_snz", 16'(snoozing), 16'd0);
    chk("dismiss_en", 16'(disp_en), 16'hF);

    // Mode and snooze together in RING: mode wins.
    ring_up("ring_b");
    expect_ev(K_ROFF, 14'd0);
    press(1, 0, 1);
    chk("ms_snz", 16'(snoozing), 16'd0);
    chk("ms_disp", disp_digit, 16'h0700);

    // Auto-dismiss after 60 ticks.
    ring_up("ring_c");
    tick(59);
    chk("auto59", 16'(alarm_ringing), 16'd1);
    tick(1);
    chk("auto60", 16'(alarm_ringing), 16'd1);
    expect_ev(K_ROFF, 14'd0);
    step();
    chk("auto_off", 16'(alarm_ringing), 16'd0);

    // Match edge beats btn_mode in RUN.
    set_cur(2'd0, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0);
    expect_ev(K_RON, 14'd0);
    step();
    press(1, 0, 0);
    chk("prio_ring", 16'(alarm_ringing), 16'd1);
    chk("prio_en", 16'(disp_en), 16'hF);
    set_cur(2'd0, 4'd7, 4'd0, 4'd0, 4'd0, 4'd1);
    expect_ev(K_ROFF, 14'd0);
    press(1, 0, 0);

    // Match while in SET_TH is ignored; then reset mid-SET_TM with a mode press.
    set_cur(2'd0, 4'd6, 4'd5, 4'd9, 4'd5, 4'd9);
    press(1, 0, 0);
    set_cur(2'd0, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0);
    repeat (3) step();
    chk("th_noring", 16'(alarm_ringing), 16'd0);
    chk("th_match_disp", disp_digit, 16'h0659);
    set_cur(2'd0, 4'd7, 4'd0, 4'd0, 4'd0, 4'd1);
    press(1, 0, 0);
    reset = 1'b1;
    press(1, 0, 0);
    reset = 1'b0;
    chk("rtm_load", 16'(set_load), 16'd0);
    chk("rtm_set", 16'({set_hh, set_hl, set_mh, set_ml}), 16'h0000);
    chk("rtm_en", 16'(disp_en), 16'hF);
    chk("rtm_disp", disp_digit, 16'h0700);
    step();
    chk("rtm_load2", 16'(set_load), 16'd0);

    // alarm_arm low clears snoozing, and dismisses a ring.
    ring_up("ring_d");
    expect_ev(K_ROFF, 14'd0);
    expect_ev(K_SON, 14'd0);
    press(0, 0, 1);
    expect_ev(K_SOFF, 14'd0);
    alarm_arm = 1'b0;
    step();
    chk("arm_snz", 16'(snoozing), 16'd0);
    alarm_arm = 1'b1;
    ring_up("ring_e");
    expect_ev(K_ROFF, 14'd0);
    alarm_arm = 1'b0;
    btn_snooze = 1'b1;
    step();
    btn_snooze = 1'b0;
    alarm_arm = 1'b1;
    chk("arm_ring", 16'(alarm_ringing), 16'd0);
    chk("arm_ring_snz", 16'(snoozing), 16'd0);

    // Reset mid-RING.
    ring_up("ring_f");
    expect_ev(K_ROFF, 14'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rr_ring", 16'(alarm_ringing), 16'd0);
    chk("rr_buzz", 16'(buzzer), 16'd0);
    chk("rr_snz", 16'(snoozing), 16'd0);
    chk("rr_load", 16'(set_load), 16'd0);

    repeat (3) step();
    chk("events_left", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
